// File: rtl/seg_display_mux.sv
// ---------------------------------------------------------------------------
// seg_display_mux
//   Time-multiplexes the stopwatch's four BCD digits (MM.SS) onto a 4-digit
//   common-anode 7-segment display. The digits are snapshotted once per scan
//   frame so a counter update can never tear across the display. The dot of
//   digit 2 (min0) forms the MM.SS separator. In adjust mode the selected
//   digit pair blinks.
//
// Ports
//   clk     : system clock
//   reset   : asynchronous, active-low reset
//   min1    : BCD tens of minutes      (shown on an[3])
//   min0    : BCD units of minutes     (shown on an[2], carries the dot)
//   sec1    : BCD tens of seconds      (shown on an[1])
//   sec0    : BCD units of seconds     (shown on an[0], rightmost)
//   adjust  : 1 = adjust mode, the selected pair blinks
//   select  : in adjust mode, 1 = seconds pair blinks, 0 = minutes pair
//   seg     : segments {g,f,e,d,c,b,a}, seg[0] = a
//   dp      : decimal point of the currently enabled digit
//   an      : digit enables, one-hot (in active form) or all inactive
// ---------------------------------------------------------------------------
module seg_display_mux #(
  parameter int SCAN_DIV       = 100_000,
  parameter int BLINK_DIV      = 25_000_000,
  parameter int ACTIVE_LOW_OUT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] min1,
  input  logic [3:0] min0,
  input  logic [3:0] sec1,
  input  logic [3:0] sec0,
  input  logic       adjust,
  input  logic       select,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam bit INV     = (ACTIVE_LOW_OUT != 0);

  logic [SCAN_W-1:0]  scan_cnt, scan_cnt_nxt;
  logic [BLINK_W-1:0] blink_cnt, blink_cnt_nxt;
  logic [1:0]         idx, idx_nxt;
  logic               blink_on, blink_on_nxt;
  logic               load_pend;
  logic [3:0][3:0]    shadow, shadow_nxt;
  logic               scan_last, load;
  logic [3:0]         digit_nxt;
  logic               blank;
  logic [6:0]         seg_hi;
  logic [3:0]         an_hi;
  logic               dp_hi;

  // Active-high segment pattern for one BCD digit; non-BCD codes go dark.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  // Next-state logic. The outputs are decoded from these next-state values
  // so that an/seg/dp switch on the very same edge as idx, with no cycle in
  // which a stale digit is shown under a new enable.
  always_comb begin
    scan_last     = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    scan_cnt_nxt  = scan_last ? '0 : scan_cnt + SCAN_W'(1);
    idx_nxt       = scan_last ? idx + 2'd1 : idx;

    // Snapshot at the frame boundary, or on the first edge after reset.
    load          = load_pend || (scan_last && (idx == 2'd3));
    shadow_nxt    = load ? {min1, min0, sec1, sec0} : shadow;

    // Outside adjust the blink phase is parked at "visible, count 0" so that
    // entering adjust always starts with a full visible half-period.
    blink_cnt_nxt = '0;
    blink_on_nxt  = 1'b1;
    if (adjust) begin
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_nxt = '0;
        blink_on_nxt  = ~blink_on;
      end else begin
        blink_cnt_nxt = blink_cnt + BLINK_W'(1);
        blink_on_nxt  = blink_on;
      end
    end

    digit_nxt = shadow_nxt[idx_nxt];
    seg_hi    = decode(digit_nxt);

    // idx 0,1 are the seconds pair, idx 2,3 the minutes pair.
    blank     = adjust && !blink_on_nxt && (select ? !idx_nxt[1] : idx_nxt[1]);
    an_hi     = blank ? 4'b0000 : (4'b0001 << idx_nxt);
    dp_hi     = (idx_nxt == 2'd2) && !blank;
  end

  // State and registered outputs. Reset drives every output to its inactive
  // level and arms a fresh snapshot for the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      idx       <= 2'd0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      shadow    <= '0;
      load_pend <= 1'b1;
      seg       <= INV ? 7'h7F : 7'h00;
      dp        <= INV ? 1'b1 : 1'b0;
      an        <= INV ? 4'hF : 4'h0;
    end else begin
      scan_cnt  <= scan_cnt_nxt;
      idx       <= idx_nxt;
      blink_cnt <= blink_cnt_nxt;
      blink_on  <= blink_on_nxt;
      shadow    <= shadow_nxt;
      load_pend <= 1'b0;
      seg       <= INV ? ~seg_hi : seg_hi;
      dp        <= INV ? ~dp_hi : dp_hi;
      an        <= INV ? ~an_hi : an_hi;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// ---------------------------------------------------------------------------
// tb_seg_display_mux
//   Directed self-checking bench for seg_display_mux with SCAN_DIV=4,
//   BLINK_DIV=16 and active-low outputs. Expected segment codes are the
//   inverted active-high table (e.g. digit 4 = ~66 = 19).
// ---------------------------------------------------------------------------
module tb_seg_display_mux;

  logic       clk;
  logic       reset;
  logic [3:0] min1, min0, sec1, sec0;
  logic       adjust, select;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int checks;
  int failures;

  // Digit enables by idx, active low.
  logic [3:0] an_tab [4];
  // Segment codes for the digits loaded as min1..sec0 = 1,2,3,7.
  logic [6:0] seg_tab [4];

  seg_display_mux #(
    .SCAN_DIV       (4),
    .BLINK_DIV      (16),
    .ACTIVE_LOW_OUT (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .min1   (min1),
    .min0   (min0),
    .sec1   (sec1),
    .sec0   (sec0),
    .adjust (adjust),
    .select (select),
    .seg    (seg),
    .dp     (dp),
    .an     (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run until the display switches onto the digit with enable 'target'
  // (first cycle of that digit), bounded so the bench cannot hang.
  task automatic sync_to(input logic [3:0] target);
    int n;
    n = 0;
    while (an == target && n < 40) begin tick(); n++; end
    while (an != target && n < 40) begin tick(); n++; end
    checks++;
    if (an != target) begin
      failures++;
      $display("[TB] FAIL sync_to: an=%b never reached %b", an, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    min1 = 4'd1; min0 = 4'd2; sec1 = 4'd3; sec0 = 4'd4;
    adjust = 1'b0; select = 1'b0;
    tick(); tick();
    checks++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_idle: an=%b seg=%h dp=%b, want 1111 7f 1", an, seg, dp);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (an !== 4'b1110 || seg !== 7'h19 || dp !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_first_edge: an=%b seg=%h dp=%b, want 1110 19 1", an, seg, dp);
    end
  endtask

  // Continues straight from test_reset: idx0 is shown for two more cycles,
  // then a full frame of idx 1,2,3,0 at four cycles each.
  task automatic test_scan();
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];
    logic       exp_dp [4];
    exp_an  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    exp_seg = '{7'h30, 7'h24, 7'h79, 7'h19};
    exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (an !== 4'b1110 || seg !== 7'h19) begin
        failures++;
        $display("[TB] FAIL scan_first_digit: an=%b seg=%h, want 1110 19", an, seg);
      end
    end
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        checks++;
        if (an !== exp_an[d] || seg !== exp_seg[d] || dp !== exp_dp[d]) begin
          failures++;
          $display("[TB] FAIL scan_d%0d_c%0d: an=%b seg=%h dp=%b, want %b %h %b",
                   d, c, an, seg, dp, exp_an[d], exp_seg[d], exp_dp[d]);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    sync_to(4'b1101);
    sec0 = 4'd5;
    tick();
    checks++;
    if (an !== 4'b1101 || seg !== 7'h30) begin
      failures++;
      $display("[TB] FAIL snap_mid_frame: an=%b seg=%h, want 1101 30", an, seg);
    end
    sync_to(4'b1110);
    checks++;
    if (seg !== 7'h12) begin
      failures++;
      $display("[TB] FAIL snap_new_frame: seg=%h, want 12", seg);
    end
    // Change while digit 0 is lit: must not tear into the current frame.
    sec0 = 4'd7;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (an !== 4'b1110 || seg !== 7'h12) begin
        failures++;
        $display("[TB] FAIL snap_no_tear_c%0d: an=%b seg=%h, want 1110 12", c, an, seg);
      end
    end
    sync_to(4'b1110);
    checks++;
    if (seg !== 7'h78) begin
      failures++;
      $display("[TB] FAIL snap_next_frame: seg=%h, want 78", seg);
    end
  endtask

  task automatic test_invalid_code();
    min1 = 4'hC;
    sync_to(4'b1110);
    sync_to(4'b1011);
    checks++;
    if (seg !== 7'h24 || dp !== 1'b0) begin
      failures++;
      $display("[TB] FAIL invalid_other_digit: seg=%h dp=%b, want 24 0", seg, dp);
    end
    sync_to(4'b0111);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (an !== 4'b0111 || seg !== 7'h7F) begin
        failures++;
        $display("[TB] FAIL invalid_blank_c%0d: an=%b seg=%h, want 0111 7f", c, an, seg);
      end
      if (c < 3) tick();
    end
    min1 = 4'd1;
    sync_to(4'b1110);
  endtask

  // Starting at the first cycle of digit 0, enable adjust and follow n edges.
  // After edge k the scan is at idx (k/4)%4; edges 16..31 fall in the dark
  // half-period of the blink.
  task automatic run_adjust(input logic sel, input int n);
    int         i;
    logic       blk;
    logic [3:0] e_an;
    logic       e_dp;
    sync_to(4'b1110);
    adjust = 1'b1;
    select = sel;
    for (int k = 1; k <= n; k++) begin
      tick();
      i    = (k / 4) % 4;
      blk  = (k >= 16 && k < 32) && (sel ? (i < 2) : (i >= 2));
      e_an = blk ? 4'b1111 : an_tab[i];
      e_dp = !((i == 2) && !blk);
      checks++;
      if (an !== e_an || dp !== e_dp || (!blk && seg !== seg_tab[i])) begin
        failures++;
        $display("[TB] FAIL adjust_sel%0d_k%0d: an=%b dp=%b seg=%h, want %b %b %h",
                 sel, k, an, dp, seg, e_an, e_dp, seg_tab[i]);
      end
    end
  endtask

  task automatic test_blink();
    // Seconds pair blinks; leave adjust while digit 0 is dark.
    run_adjust(1'b1, 19);
    adjust = 1'b0;
    tick();
    checks++;
    if (an !== 4'b1101 || seg !== 7'h30) begin
      failures++;
      $display("[TB] FAIL adjust_exit: an=%b seg=%h, want 1101 30", an, seg);
    end
    // Minutes pair blinks, including the separator dot.
    run_adjust(1'b0, 31);
    adjust = 1'b0;
    tick();
    checks++;
    if (an !== 4'b1110 || seg !== 7'h78) begin
      failures++;
      $display("[TB] FAIL adjust_exit_min: an=%b seg=%h, want 1110 78", an, seg);
    end
  endtask

  task automatic test_reset_mid();
    sync_to(4'b1011);
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_async: an=%b seg=%h dp=%b, want 1111 7f 1", an, seg, dp);
    end
    sec0 = 4'd9;
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++;
    if (an !== 4'b1110 || seg !== 7'h10) begin
      failures++;
      $display("[TB] FAIL reset_mid_restart: an=%b seg=%h, want 1110 10", an, seg);
    end
    tick(); tick(); tick();
    checks++;
    if (an !== 4'b1101 || seg !== 7'h30) begin
      failures++;
      $display("[TB] FAIL reset_mid_next_digit: an=%b seg=%h, want 1101 30", an, seg);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    an_tab   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab  = '{7'h78, 7'h30, 7'h24, 7'h79};
    test_reset();
    test_scan();
    test_snapshot();
    test_invalid_code();
    test_blink();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
